// File: rtl/voice_tick_scheduler_pkg.sv
// Shared definitions for the voice tick scheduler: sequencer state encoding
// and the smallest sample period the tick generator will run with.
package voice_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        MIX  = 2'd2
    } sched_state_t;

    // Divisors below this are raised to it; a 1-cycle period cannot wrap cleanly.
    localparam int DIV_MIN = 2;

endpackage

// File: rtl/voice_tick_scheduler_if.sv
// Handshake bundle of the voice tick scheduler: divisor configuration channel
// and the voice request channel toward the shared voice datapath.
interface voice_tick_scheduler_if #(
    parameter int DIV_WIDTH = 16,
    parameter int IDX_W     = 2
);
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [DIV_WIDTH-1:0] cfg_divisor;
    logic                 voice_valid;
    logic [IDX_W-1:0]     voice_idx;
    logic                 voice_ready;

    modport master (
        output cfg_valid, cfg_divisor, voice_ready,
        input  cfg_ready, voice_valid, voice_idx
    );

    modport slave (
        input  cfg_valid, cfg_divisor, voice_ready,
        output cfg_ready, voice_valid, voice_idx
    );
endinterface

// File: rtl/voice_tick_scheduler_tick_gen.sv
// Sample-period generator: free-running period counter, active divisor and a
// one-deep pending divisor that is swapped in only at the counter wrap.
module tick_gen
    import voice_sched_pkg::*;
#(
    parameter int DIV_WIDTH   = 16,
    parameter int DEFAULT_DIV = 48
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_valid,
    input  logic [DIV_WIDTH-1:0] cfg_divisor,
    output logic                 cfg_ready,
    output logic                 sample_tick
);

    localparam logic [DIV_WIDTH-1:0] DIV_FLOOR = DIV_WIDTH'(DIV_MIN);
    localparam logic [DIV_WIDTH-1:0] DIV_RESET =
        (DEFAULT_DIV < DIV_MIN) ? DIV_FLOOR : DIV_WIDTH'(DEFAULT_DIV);

    function automatic logic [DIV_WIDTH-1:0] clamp_div(input logic [DIV_WIDTH-1:0] d);
        return (d < DIV_FLOOR) ? DIV_FLOOR : d;
    endfunction

    logic [DIV_WIDTH-1:0] cnt;
    logic [DIV_WIDTH-1:0] div;
    logic [DIV_WIDTH-1:0] pend_div;
    logic                 pend;
    logic                 wrap;

    assign wrap        = (cnt == div - DIV_WIDTH'(1));
    assign sample_tick = wrap;
    assign cfg_ready   = !pend;

    // Accept and apply are exclusive: accept needs !pend, apply needs pend.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            div      <= DIV_RESET;
            pend     <= 1'b0;
            pend_div <= DIV_RESET;
        end else begin
            if (wrap) begin
                cnt <= '0;
                if (pend) begin
                    div  <= pend_div;
                    pend <= 1'b0;
                end
            end else begin
                cnt <= cnt + DIV_WIDTH'(1);
            end
            if (cfg_valid && !pend) begin
                pend     <= 1'b1;
                pend_div <= clamp_div(cfg_divisor);
            end
        end
    end

endmodule

// File: rtl/voice_tick_scheduler.sv
// Voice tick scheduler top: tick_gen plus the IDLE/RUN/MIX voice sequencer.
// Define VOICE_SCHED_OVERRUN_EN to get the sticky overrun flag.
module voice_tick_scheduler
    import voice_sched_pkg::*;
#(
    parameter int NUM_VOICES  = 4,
    parameter int DIV_WIDTH   = 16,
    parameter int DEFAULT_DIV = 48
) (
    input  logic                   clk,
    input  logic                   rst,
    voice_tick_scheduler_if.slave  sched,
    output logic                   sample_tick,
    output logic                   mix_strobe,
    output logic                   busy,
    output logic                   overrun,
    input  logic                   overrun_clr
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    logic tick;

    tick_gen #(
        .DIV_WIDTH   (DIV_WIDTH),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_tick_gen (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (sched.cfg_valid),
        .cfg_divisor (sched.cfg_divisor),
        .cfg_ready   (sched.cfg_ready),
        .sample_tick (tick)
    );

    assign sample_tick = tick;

    sched_state_t     state;
    logic [IDX_W-1:0] idx;
    logic             vld_r;
    logic             mix_r;
    logic             busy_r;

    // Outputs are registered next to the state so they never glitch on decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            vld_r  <= 1'b0;
            mix_r  <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (tick) begin
                        state  <= RUN;
                        idx    <= '0;
                        vld_r  <= 1'b1;
                        busy_r <= 1'b1;
                    end
                end
                RUN: begin
                    if (sched.voice_ready) begin
                        if (idx == LAST_IDX) begin
                            state <= MIX;
                            idx   <= '0;
                            vld_r <= 1'b0;
                            mix_r <= 1'b1;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                MIX: begin
                    state  <= IDLE;
                    mix_r  <= 1'b0;
                    busy_r <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    idx    <= '0;
                    vld_r  <= 1'b0;
                    mix_r  <= 1'b0;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign sched.voice_valid = vld_r;
    assign sched.voice_idx   = idx;
    assign mix_strobe        = mix_r;
    assign busy              = busy_r;

`ifdef VOICE_SCHED_OVERRUN_EN
    logic ovr;

    // A tick that lands in RUN or MIX is dropped; setting beats clearing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr <= 1'b0;
        end else if (tick && (state != IDLE)) begin
            ovr <= 1'b1;
        end else if (overrun_clr) begin
            ovr <= 1'b0;
        end
    end

    assign overrun = ovr;
`else
    logic unused_clr;
    assign unused_clr = overrun_clr;
    assign overrun    = 1'b0;
`endif

endmodule
